// File: rtl/regfile_scoreboard.sv
// Architectural integer register file with write-first read bypass and a
// per-register pending-write scoreboard for decode-side RAW hazard detection.

module regfile_scoreboard_cnt #(
   parameter int CNTW = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            inc,
   input  logic            dec,
   input  logic            flush,
   output logic [CNTW-1:0] cnt
);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         cnt <= '0;
      else if (flush)
         cnt <= '0;
      else if (inc && !dec)
         cnt <= cnt + 1'b1;
      else if (dec && !inc)
         cnt <= cnt - 1'b1;
   end
endmodule

module regfile_scoreboard #(
   parameter int NREG = 32,
   parameter int XLEN = 64,
   parameter int AW   = 5,
   parameter int CNTW = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            hazard1,
   output logic            hazard2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            issue_ready,
   input  logic            wvalid,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic            flush,
   output logic            sb_err
);
   localparam logic [CNTW-1:0] CMAX = '1;
   localparam logic [CNTW-1:0] ONE  = CNTW'(1);

   logic [XLEN-1:0] regs [NREG];
   logic [CNTW-1:0] cnt  [NREG];
   logic [NREG-1:1] inc;
   logic [NREG-1:1] dec;
   logic            wr_en;

   assign wr_en  = wvalid && (wa != '0);
   assign cnt[0] = '0;

   // Data commits even under flush; only the pending tracking is discarded.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wa] <= wd;
      end
   end

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      assign inc[i] = issue_valid && issue_ready && (issue_rd == AW'(i));
      assign dec[i] = wvalid && (wa == AW'(i)) && (cnt[i] != '0);
      regfile_scoreboard_cnt #(.CNTW(CNTW)) u_cnt (
         .clk    (clk),
         .resetn (resetn),
         .inc    (inc[i]),
         .dec    (dec[i]),
         .flush  (flush),
         .cnt    (cnt[i])
      );
   end

   // Reads are forced to zero while reset is held so bypass cannot leak wd.
   assign rd1 = (!resetn || ra1 == '0) ? '0 : (wvalid && wa == ra1) ? wd : regs[ra1];
   assign rd2 = (!resetn || ra2 == '0) ? '0 : (wvalid && wa == ra2) ? wd : regs[ra2];

   // The last outstanding write committing now is covered by the bypass.
   assign hazard1 = (ra1 != '0) &&
                    ((cnt[ra1] > ONE) || (cnt[ra1] == ONE && !(wvalid && wa == ra1)));
   assign hazard2 = (ra2 != '0) &&
                    ((cnt[ra2] > ONE) || (cnt[ra2] == ONE && !(wvalid && wa == ra2)));

   assign issue_ready = !((issue_rd != '0) && (cnt[issue_rd] == CMAX) &&
                          !(wvalid && wa == issue_rd));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         sb_err <= 1'b0;
      else if (wr_en && cnt[wa] == '0 && !flush)
         sb_err <= 1'b1;
   end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: array/integer model checked every
// negedge, plus literal expectations at the interesting points.

module tb_regfile_scoreboard;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [4:0]  ra1 = '0, ra2 = '0, issue_rd = '0, wa = '0;
   logic [63:0] rd1, rd2, wd = '0;
   logic        hazard1, hazard2, issue_ready, sb_err;
   logic        issue_valid = 1'b0, wvalid = 1'b0, flush = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m_reg [32];
   int          m_cnt [32];
   bit          m_err;

   regfile_scoreboard dut (
      .clk(clk), .resetn(resetn), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .hazard1(hazard1), .hazard2(hazard2), .issue_valid(issue_valid),
      .issue_rd(issue_rd), .issue_ready(issue_ready), .wvalid(wvalid),
      .wa(wa), .wd(wd), .flush(flush), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
      m_err = 1'b0;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_rd(input logic [4:0] ra);
      if (!resetn || ra == 0) return 64'd0;
      if (wvalid && wa == ra) return wd;
      return m_reg[ra];
   endfunction

   function automatic logic exp_haz(input logic [4:0] ra);
      if (!resetn || ra == 0) return 1'b0;
      if (m_cnt[ra] >= 2) return 1'b1;
      return (m_cnt[ra] == 1) && !(wvalid && wa == ra);
   endfunction

   function automatic logic exp_ready();
      if (!resetn || issue_rd == 0 || m_cnt[issue_rd] < 7) return 1'b1;
      return wvalid && wa == issue_rd;
   endfunction

   always @(posedge clk or negedge resetn) begin
      bit rdy, do_dec;
      if (!resetn) begin
         for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_cnt[i] = 0; end
         m_err = 1'b0;
      end else begin
         rdy    = exp_ready();
         do_dec = wvalid && wa != 0 && m_cnt[wa] > 0;
         if (wvalid && wa != 0) begin
            if (m_cnt[wa] == 0 && !flush) m_err = 1'b1;
            m_reg[wa] = wd;
         end
         if (flush) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
         end else begin
            if (issue_valid && rdy && issue_rd != 0) m_cnt[issue_rd]++;
            if (do_dec) m_cnt[wa]--;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_rd1", rd1, exp_rd(ra1));
      chk("m_rd2", rd2, exp_rd(ra2));
      chk("m_hazard1", {63'd0, hazard1}, {63'd0, exp_haz(ra1)});
      chk("m_hazard2", {63'd0, hazard2}, {63'd0, exp_haz(ra2)});
      chk("m_issue_ready", {63'd0, issue_ready}, {63'd0, exp_ready()});
      chk("m_sb_err", {63'd0, sb_err}, {63'd0, m_err});
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
      issue_valid = 1'b0; wvalid = 1'b0; flush = 1'b0;
   endtask

   task automatic issue(input logic [4:0] r);
      issue_valid = 1'b1; issue_rd = r;
      @(negedge clk);
      next_cyc();
   endtask

   initial begin
      // Held in reset: outputs idle even with a write presented
      ra1 = 5; wvalid = 1'b1; wa = 5; wd = 64'h1234;
      repeat (2) @(negedge clk);
      chk("rst_rd1", rd1, 64'd0);
      chk("rst_ready", {63'd0, issue_ready}, 64'd1);
      @(posedge clk); #1;
      resetn = 1'b1; wvalid = 1'b0;

      // 1: reset state read
      ra1 = 5; ra2 = 0;
      @(negedge clk);
      chk("t1_rd1", rd1, 64'd0);
      chk("t1_rd2", rd2, 64'd0);
      chk("t1_haz1", {63'd0, hazard1}, 64'd0);
      chk("t1_sberr", {63'd0, sb_err}, 64'd0);
      next_cyc();

      // 2: write/bypass (x5 issued first so the commit is legitimate)
      issue(5);
      wvalid = 1'b1; wa = 5; wd = 64'hDEAD_BEEF_0000_0001;
      @(negedge clk);
      chk("t2_bypass", rd1, 64'hDEAD_BEEF_0000_0001);
      chk("t2_haz1_last", {63'd0, hazard1}, 64'd0);
      next_cyc();
      @(negedge clk);
      chk("t2_stored", rd1, 64'hDEAD_BEEF_0000_0001);
      next_cyc();
      wvalid = 1'b1; wa = 0; wd = 64'd7; ra1 = 0;
      @(negedge clk);
      chk("t2_x0_byp", rd1, 64'd0);
      next_cyc();
      @(negedge clk);
      chk("t2_x0", rd1, 64'd0);
      chk("t2_sberr", {63'd0, sb_err}, 64'd0);
      next_cyc();

      // 3: hazard tracking on x3
      issue(3); issue(3);
      ra1 = 3;
      @(negedge clk);
      chk("t3_haz_cnt2", {63'd0, hazard1}, 64'd1);
      next_cyc();
      wvalid = 1'b1; wa = 3; wd = 64'h33;
      @(negedge clk);
      chk("t3_haz_wb1", {63'd0, hazard1}, 64'd1);
      next_cyc();
      wvalid = 1'b1; wa = 3; wd = 64'h44;
      @(negedge clk);
      chk("t3_haz_wb2", {63'd0, hazard1}, 64'd0);
      chk("t3_rd_wb2", rd1, 64'h44);
      next_cyc();
      @(negedge clk);
      chk("t3_haz_done", {63'd0, hazard1}, 64'd0);
      next_cyc();

      // 4: saturation on x7
      for (int i = 0; i < 7; i++) issue(7);
      issue_valid = 1'b1; issue_rd = 7; ra2 = 7;
      @(negedge clk);
      chk("t4_sat_ready", {63'd0, issue_ready}, 64'd0);
      chk("t4_sat_haz2", {63'd0, hazard2}, 64'd1);
      next_cyc();
      issue_valid = 1'b1; issue_rd = 7; wvalid = 1'b1; wa = 7; wd = 64'h77;
      @(negedge clk);
      chk("t4_ready_wb", {63'd0, issue_ready}, 64'd1);
      next_cyc();
      issue_rd = 7;
      @(negedge clk);
      chk("t4_still_sat", {63'd0, issue_ready}, 64'd0);
      next_cyc();

      // 5: simultaneous inc/dec on x4, then flush
      issue(4);
      issue_valid = 1'b1; issue_rd = 4; wvalid = 1'b1; wa = 4; wd = 64'h4;
      @(negedge clk);
      next_cyc();
      ra1 = 4; wvalid = 1'b1; wa = 4; wd = 64'h40;
      @(negedge clk);
      chk("t5_cnt1_haz", {63'd0, hazard1}, 64'd0);
      chk("t5_rd", rd1, 64'h40);
      next_cyc();
      issue(4); issue(4);
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 4;
      @(negedge clk);
      chk("t5_pre_flush", {63'd0, hazard1}, 64'd1);
      next_cyc();
      issue_rd = 7;
      @(negedge clk);
      chk("t5_flush_haz1", {63'd0, hazard1}, 64'd0);
      chk("t5_flush_haz2", {63'd0, hazard2}, 64'd0);
      chk("t5_flush_ready", {63'd0, issue_ready}, 64'd1);
      next_cyc();

      // 6: flush suppresses error, then unmatched writeback sets it
      flush = 1'b1; wvalid = 1'b1; wa = 10; wd = 64'hA0;
      @(negedge clk);
      next_cyc();
      ra1 = 10;
      @(negedge clk);
      chk("t6_flush_noerr", {63'd0, sb_err}, 64'd0);
      chk("t6_flush_data", rd1, 64'hA0);
      next_cyc();
      wvalid = 1'b1; wa = 9; wd = 64'h99;
      @(negedge clk);
      next_cyc();
      ra1 = 9; ra2 = 5;
      @(negedge clk);
      chk("t6_err_set", {63'd0, sb_err}, 64'd1);
      chk("t6_err_data", rd1, 64'h99);
      next_cyc();
      @(negedge clk);
      chk("t6_err_sticky", {63'd0, sb_err}, 64'd1);
      next_cyc();

      // Asynchronous reset between edges
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_err", {63'd0, sb_err}, 64'd0);
      chk("t6_async_rd1", rd1, 64'd0);
      chk("t6_async_rd2", rd2, 64'd0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(negedge clk);
      chk("t6_post_rd1", rd1, 64'd0);
      chk("t6_post_rd2", rd2, 64'd0);
      chk("t6_post_err", {63'd0, sb_err}, 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
